fdiv_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider with valid/ready handshakes on both sides.
- Computes a/b by restoring mantissa division, one quotient bit per cycle, so the combinational divide path is off the critical path.
- Sits beside the floating-point ALU as the sequential divide unit: an upstream issuer presents operands, and the downstream consumer takes the result plus exception flags.

---
 rtl/fdiv_seq_if.sv | 24 ++
 rtl/fdiv_seq.sv | 175 +++++++++++++++++
 tb/tb_fdiv_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fdiv_seq_if.sv
// Operand/result handshake bundle for the sequential FP divider.
// master = issuer/consumer side, slave = the divider itself.
interface fdiv_seq_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [4:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, flags
  );
endinterface

// File: rtl/fdiv_seq.sv
// Sequential IEEE-754 single divider: restoring mantissa division, one
// quotient bit per cycle, round-to-nearest-even, denormals flushed to zero.
module fdiv_seq #(
  parameter int N  = 32,
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int QB = MW + 3
) (
  input  logic      clk,
  input  logic      rst,
  fdiv_seq_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [4:0]    CNT_INIT = 5'(QB - 1);
  localparam logic [EW-1:0] EXP_MAX  = '1;
  localparam logic [N-1:0]  QNAN     = 32'h7FC0_0000;

  logic [2:0]        state_reg;
  logic [N-1:0]      a_reg, b_reg, out_reg;
  logic [4:0]        flags_reg;
  logic              sign_reg;
  logic signed [9:0] exp_reg;
  logic [MW:0]       mb_reg;
  logic [MW+1:0]     rem_reg;
  logic [QB-1:0]     q_reg;
  logic [4:0]        cnt_reg;

  logic [N-1:0]  opnd    [2];
  logic [EW-1:0] op_exp  [2];
  logic [MW:0]   op_man  [2];
  logic [1:0]    op_sign, op_zero, op_inf, op_nan;

  assign opnd[0] = a_reg;
  assign opnd[1] = b_reg;

  // A zero exponent covers both true zero and flushed denormals.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_class
      assign op_sign[gi] = opnd[gi][N-1];
      assign op_exp[gi]  = opnd[gi][N-2:MW];
      assign op_man[gi]  = {1'b1, opnd[gi][MW-1:0]};
      assign op_zero[gi] = (op_exp[gi] == '0);
      assign op_inf[gi]  = (op_exp[gi] == EXP_MAX) && (opnd[gi][MW-1:0] == '0);
      assign op_nan[gi]  = (op_exp[gi] == EXP_MAX) && (opnd[gi][MW-1:0] != '0);
    end
  endgenerate

  logic res_sign, is_nv, is_dz, is_inf_res, is_zero_res, man_lt;
  logic signed [9:0] exp_unp;

  assign res_sign    = op_sign[0] ^ op_sign[1];
  assign is_nv       = (|op_nan) | (&op_zero) | (&op_inf);
  assign is_dz       = !op_inf[0] && op_zero[1];
  assign is_inf_res  = op_inf[0];
  assign is_zero_res = op_inf[1] | op_zero[0];
  assign exp_unp     = $signed({2'b00, op_exp[0]} - {2'b00, op_exp[1]} + 10'd127);
  assign man_lt      = (op_man[0] < op_man[1]);

  logic [MW+2:0] trial;
  logic [MW+1:0] rem_keep;

  assign trial    = {1'b0, rem_reg} - {2'b00, mb_reg};
  assign rem_keep = trial[MW+2] ? rem_reg : trial[MW+1:0];

  logic [MW:0]       mant;
  logic              guard, rbit, sticky, round_up, carry, ovf, unf;
  logic [MW+1:0]     mant_r;
  logic [MW-1:0]     frac_r;
  logic signed [9:0] exp_r;

  assign mant     = q_reg[QB-1:2];
  assign guard    = q_reg[1];
  assign rbit     = q_reg[0];
  assign sticky   = |rem_reg;
  assign round_up = guard & (rbit | sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + {{(MW+1){1'b0}}, round_up};
  assign carry    = mant_r[MW+1];
  assign frac_r   = carry ? mant_r[MW:1] : mant_r[MW-1:0];
  assign exp_r    = exp_reg + $signed({9'd0, carry});
  assign ovf      = (exp_r >= 10'sd255);
  assign unf      = (exp_r <= 10'sd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      flags_reg <= '0;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      mb_reg    <= '0;
      rem_reg   <= '0;
      q_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            state_reg <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_reg <= res_sign;
          mb_reg   <= op_man[1];
          cnt_reg  <= CNT_INIT;
          q_reg    <= '0;
          if (is_nv) begin
            out_reg   <= QNAN;
            flags_reg <= 5'b10000;
            state_reg <= S_DONE;
          end else if (is_dz) begin
            out_reg   <= {res_sign, EXP_MAX, {MW{1'b0}}};
            flags_reg <= 5'b01000;
            state_reg <= S_DONE;
          end else if (is_inf_res) begin
            out_reg   <= {res_sign, EXP_MAX, {MW{1'b0}}};
            flags_reg <= 5'b00000;
            state_reg <= S_DONE;
          end else if (is_zero_res) begin
            out_reg   <= {res_sign, {(N-1){1'b0}}};
            flags_reg <= 5'b00000;
            state_reg <= S_DONE;
          end else begin
            // Pre-normalise so the first quotient bit is always the integer 1.
            if (man_lt) begin
              rem_reg <= {op_man[0], 1'b0};
              exp_reg <= exp_unp - 10'sd1;
            end else begin
              rem_reg <= {1'b0, op_man[0]};
              exp_reg <= exp_unp;
            end
            state_reg <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_reg <= rem_keep << 1;
          q_reg   <= {q_reg[QB-2:0], ~trial[MW+2]};
          if (cnt_reg == 5'd0) state_reg <= S_ROUND;
          else                 cnt_reg   <= cnt_reg - 5'd1;
        end
        S_ROUND: begin
          if (ovf) begin
            out_reg   <= {sign_reg, EXP_MAX, {MW{1'b0}}};
            flags_reg <= 5'b00101;
          end else if (unf) begin
            out_reg   <= {sign_reg, {(N-1){1'b0}}};
            flags_reg <= 5'b00011;
          end else begin
            out_reg   <= {sign_reg, exp_r[EW-1:0], frac_r};
            flags_reg <= {4'b0000, guard | rbit | sticky};
          end
          state_reg <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == S_IDLE);
  assign bus.out_valid = (state_reg == S_DONE);
  assign bus.out       = out_reg;
  assign bus.flags     = flags_reg;
endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq: scoreboarded results, latency, hold-off and
// mid-divide reset behaviour.
module tb_fdiv_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fdiv_seq_if #(.N(32)) bus ();

  fdiv_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns the same way.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eo, input logic [4:0] ef, input int elat,
                       input int hold);
    exp_t e;
    int cyc;
    logic [31:0] held_out;
    logic [4:0]  held_fl;
    sb.push_back('{eo, ef, elat});
    bus.a         = av;
    bus.b         = bv;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.in_valid = 1'b0;
      if (bus.out_valid === 1'b1) break;
    end
    e = sb.pop_front();
    check({tag, " latency"}, 32'(cyc), 32'(e.lat));
    check({tag, " out"}, bus.out, e.res);
    check({tag, " flags"}, {27'd0, bus.flags}, {27'd0, e.fl});
    $display("op %s a=%h b=%h out=%h flags=%b cycle=%0d", tag, av, bv, bus.out, bus.flags, cyc);
    if (hold > 0) begin
      held_out = bus.out;
      held_fl  = bus.flags;
      repeat (hold) begin
        bus.in_valid = 1'b1;
        bus.a        = $urandom;
        bus.b        = $urandom;
        @(posedge clk);
        #1;
        check({tag, " hold out"}, bus.out, held_out);
        check({tag, " hold flags"}, {27'd0, bus.flags}, {27'd0, held_fl});
        check({tag, " hold valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, " hold in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " back to idle"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, " valid dropped"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out", bus.out, 32'd0);
    check("reset flags", {27'd0, bus.flags}, 32'd0);

    do_op("6/2",        32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 0);
    do_op("1/3",        32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29, 0);
    do_op("1/0",        32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, 0);
    do_op("0/0",        32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, 0);
    do_op("overflow",   32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101, 29, 0);
    do_op("underflow",  32'h00800000, 32'h4B000000, 32'h00000000, 5'b00011, 29, 0);
    do_op("nan/1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2, 0);
    do_op("inf/inf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 2, 0);
    do_op("-inf/2",     32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 2, 0);
    do_op("inf/0",      32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 2, 0);
    do_op("2/-inf",     32'h40000000, 32'hFF800000, 32'h80000000, 5'b00000, 2, 0);
    do_op("-0/3",       32'h80000000, 32'h40400000, 32'h80000000, 5'b00000, 2, 0);
    do_op("denorm/1",   32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 2, 0);
    do_op("1/denorm",   32'h3F800000, 32'h807FFFFF, 32'hFF800000, 5'b01000, 2, 0);
    do_op("-6/2",       32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 29, 0);
    do_op("1.5/1.5",    32'h3FC00000, 32'h3FC00000, 32'h3F800000, 5'b00000, 29, 0);
    do_op("7/2 hold",   32'h40E00000, 32'h40000000, 32'h40600000, 5'b00000, 29, 10);

    // Abort a divide with reset during its tenth cycle.
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid-divide busy", {31'd0, bus.in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort out", bus.out, 32'd0);
    check("abort flags", {27'd0, bus.flags}, 32'd0);
    check("abort in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("op reset-abort out=%h flags=%b", bus.out, bus.flags);

    do_op("6/2 after rst", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 29, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
